// File: rtl/rs_encoder_239.sv
// rs_encoder_239
//   Systematic RS(255,239) encoder over GF(2^8), primitive polynomial 0x11D,
//   alpha = 0x02, generator g(x) = prod_{i=0..15} (x + alpha^i).
//   Message bytes are forwarded unchanged with one cycle of latency. The
//   16 parity bytes p15..p0 follow the last message byte with no gap.
//   K < 239 gives a shortened code (implicit leading zero bytes).
//
// Ports
//   i_clk    : rising-edge clock
//   i_rst    : asynchronous active-high reset, clears all state
//   i_valid  : i_data carries a message byte
//   i_data   : message byte, highest-degree coefficient first
//   o_ready  : encoder accepts a byte this cycle (low during parity phase)
//   o_valid  : o_data carries a codeword byte (no backpressure)
//   o_data   : codeword byte: K message bytes then p15..p0
//   o_first  : first byte of a codeword, qualified by o_valid
//   o_last   : final parity byte p0, qualified by o_valid

module rs_encoder_239 #(
  parameter int unsigned K = 239
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_first,
  output logic       o_last
);

  localparam int unsigned NPAR = 16;
  localparam int unsigned CW   = (K > 1) ? $clog2(K) : 1;

  // Generator coefficients g15..g0 (packed index i holds g_i).
  // Derivation: multiply out (x + alpha^0)(x + alpha^1)...(x + alpha^15) in
  // GF(2^8)/0x11D; the monic result is
  //   x^16 + 59x^15 + 13x^14 + 104x^13 + 189x^12 + 68x^11 + 209x^10 + 30x^9
  //   + 8x^8 + 163x^7 + 65x^6 + 41x^5 + 229x^4 + 98x^3 + 50x^2 + 36x + 59.
  // Cross-checks: g15 = sum of the roots = 0x3B, g0 = alpha^120 = 0x3B.
  localparam logic [NPAR-1:0][7:0] G = {
    8'd59,  8'd13,  8'd104, 8'd189,   // g15..g12
    8'd68,  8'd209, 8'd30,  8'd8,     // g11..g8
    8'd163, 8'd65,  8'd41,  8'd229,   // g7..g4
    8'd98,  8'd50,  8'd36,  8'd59     // g3..g0
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MSG  = 2'd1,
    S_PAR  = 2'd2
  } state_t;

  // GF(2^8) multiply, shift-and-add with reduction by 0x11D. Called with a
  // constant second operand, so each instance reduces to an XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  state_t                 r_state;
  logic                   r_armed;
  logic [NPAR-1:0][7:0]   r_lfsr;
  logic [CW-1:0]          r_mcnt;
  logic [3:0]             r_pcnt;
  logic                   r_ready;
  logic                   r_valid;
  logic [7:0]             r_data;
  logic                   r_first;
  logic                   r_last;

  logic                   w_accept;
  logic                   w_msg_end;
  logic                   w_par_end;
  logic [7:0]             w_fb;
  logic [NPAR-1:0][7:0]   w_prod;
  logic [NPAR-1:0][7:0]   w_lfsr_upd;

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_first = r_first;
  assign o_last  = r_last;

  // r_ready is only ever high in S_MSG, so it also qualifies the state.
  assign w_accept  = i_valid & r_ready;
  assign w_msg_end = (r_mcnt == CW'(K - 1));
  assign w_par_end = (r_pcnt == 4'd15);

  // Division step for one message byte: feedback into every tap.
  always_comb begin
    w_fb = i_data ^ r_lfsr[NPAR-1];
    for (int unsigned i = 0; i < NPAR; i++) begin
      w_prod[i] = gf_mul(w_fb, G[i]);
    end
    w_lfsr_upd[0] = w_prod[0];
    for (int unsigned i = 1; i < NPAR; i++) begin
      w_lfsr_upd[i] = r_lfsr[i-1] ^ w_prod[i];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_armed <= 1'b0;
      r_lfsr  <= '0;
      r_mcnt  <= '0;
      r_pcnt  <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      unique case (r_state)
        // Two clocks in IDLE after reset release: the first arms, the
        // second enters MSG with o_ready registered high.
        S_IDLE: begin
          r_valid <= 1'b0;
          r_first <= 1'b0;
          r_last  <= 1'b0;
          if (r_armed) begin
            r_state <= S_MSG;
            r_ready <= 1'b1;
          end else begin
            r_armed <= 1'b1;
          end
        end

        S_MSG: begin
          r_last <= 1'b0;
          if (w_accept) begin
            r_lfsr  <= w_lfsr_upd;
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_first <= (r_mcnt == '0);
            if (w_msg_end) begin
              r_mcnt  <= '0;
              r_state <= S_PAR;
              r_ready <= 1'b0;
            end else begin
              r_mcnt <= r_mcnt + 1'b1;
            end
          end else begin
            r_valid <= 1'b0;
            r_first <= 1'b0;
          end
        end

        // Feedback forced to zero: plain upward shift, emitting r15.
        S_PAR: begin
          r_valid <= 1'b1;
          r_first <= 1'b0;
          r_data  <= r_lfsr[NPAR-1];
          r_last  <= w_par_end;
          if (w_par_end) begin
            r_lfsr  <= '0;
            r_pcnt  <= '0;
            r_state <= S_MSG;
            r_ready <= 1'b1;
          end else begin
            r_lfsr <= {r_lfsr[NPAR-2:0], 8'h00};
            r_pcnt <= r_pcnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_valid <= 1'b0;
          r_first <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
